// File: rtl/drum_mem_responder.sv
// ---------------------------------------------------------------------------
// drum_mem_responder
//
// Responder side of the pulse-sequencer memory handshake. Models a rotating
// drum store: a request is latched, the block waits until the addressed word
// passes under the heads, performs the read or write, then emits a
// single-cycle reply.
//
// Build option:
//   DRUM_LATENCY_EN  defined   -> rotational wait before every access
//                    undefined -> fixed two-cycle access (IDLE->ACCESS->REPLY);
//                                 the drum counters keep running but never
//                                 gate the access
//
// Ports:
//   clk                clock
//   resetn             synchronous, active-low reset
//   mem_read_pulse_i   one-cycle read request
//   mem_write_pulse_i  one-cycle write request (wins over a read in the same cycle)
//   mem_addr_i         request address, sampled with the pulse
//   mem_wdata_i        write word, sampled with the pulse
//   mem_reply_o        one-cycle access-complete pulse
//   mem_rdata_o        last read word, held until the next read completes
//   mem_busy_o         high whenever a request is in flight
//   mem_err_o          sticky protocol-error flag, cleared only by reset
//   drum_pos_o         word currently under the heads
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request
// WAIT   | request latched, waiting for the addressed word to come round
// ACCESS | fixed-latency access (no-drum build)
// REPLY  | access done, mem_reply_o high for this cycle
// ---------------------------------------------------------------------------
module drum_mem_responder #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 31,
    parameter int SECTOR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_read_pulse_i,
    input  logic              mem_write_pulse_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_reply_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_busy_o,
    output logic              mem_err_o,
    output logic [ADDR_W-1:0] drum_pos_o
);

    localparam int PH_W = $clog2(SECTOR_CYCLES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SECTOR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_REPLY  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              op_wr_q, op_wr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q;
    logic              do_access;
    logic              req_any;

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

`ifdef DRUM_LATENCY_EN
    // The access happens on the edge that ends the last phase of the
    // addressed word time.
    logic at_match;
    assign at_match = (pos_q == addr_q) && (phase_q == PH_LAST);
`endif

    assign req_any = mem_read_pulse_i | mem_write_pulse_i;

    // Free-running drum counters.
    always_comb begin
        phase_d = phase_q + PH_W'(1);
        pos_d   = pos_q;
        if (phase_q == PH_LAST) begin
            phase_d = '0;
            pos_d   = pos_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        do_access = 1'b0;

        // Any pulse outside IDLE is dropped; a double pulse in IDLE is
        // accepted as a write. Both are protocol errors.
        err_d = err_q
              | (req_any && (state_q != ST_IDLE))
              | (mem_read_pulse_i && mem_write_pulse_i);

        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    op_wr_d = mem_write_pulse_i;
`ifdef DRUM_LATENCY_EN
                    state_d = ST_WAIT;
`else
                    state_d = ST_ACCESS;
`endif
                end
            end
`ifdef DRUM_LATENCY_EN
            ST_WAIT: begin
                if (at_match) begin
                    do_access = 1'b1;
                    state_d   = ST_REPLY;
                end
            end
`endif
            ST_ACCESS: begin
                do_access = 1'b1;
                state_d   = ST_REPLY;
            end
            ST_REPLY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            pos_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            err_q   <= err_d;
            if (do_access && !op_wr_q) begin
                rdata_q <= mem_q[addr_q];
            end
        end
    end

    // Storage is never cleared; a reset on the access edge suppresses the
    // write so an abandoned request never reaches the array.
    always_ff @(posedge clk) begin
        if (resetn && do_access && op_wr_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign mem_reply_o = (state_q == ST_REPLY);
    assign mem_busy_o  = (state_q != ST_IDLE);
    assign mem_err_o   = err_q;
    assign mem_rdata_o = rdata_q;
    assign drum_pos_o  = pos_q;

endmodule

// File: tb/tb_drum_mem_responder.sv
module tb_drum_mem_responder;

    localparam int AW = 3;
    localparam int DW = 31;
    localparam int SC = 2;
    localparam int NW = 1 << AW;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          mem_read_pulse = 1'b0;
    logic          mem_write_pulse = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          mem_reply;
    logic [DW-1:0] mem_rdata;
    logic          mem_busy;
    logic          mem_err;
    logic [AW-1:0] drum_pos;

    drum_mem_responder #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .SECTOR_CYCLES(SC)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .mem_read_pulse_i(mem_read_pulse),
        .mem_write_pulse_i(mem_write_pulse),
        .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_reply_o(mem_reply),
        .mem_rdata_o(mem_rdata),
        .mem_busy_o(mem_busy),
        .mem_err_o(mem_err),
        .drum_pos_o(drum_pos)
    );

    always #5 clk = ~clk;

    // Cycle numbering: cycle 0 is the first cycle whose closing edge sees
    // resetn high.
    int cyc = 0;
    bit rst_edge = 1'b1;
    always @(posedge clk) begin
        rst_edge <= !resetn;
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        int            cyc;
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            vectors = 0;
    int            miscompares = 0;

    // Reference model state
    logic [DW-1:0] mem_m [NW];
    logic [DW-1:0] rdata_m = '0;
    int            cur_reply = -1;
    int            cur_t = -1;
    int            err_from = NEVER;
    bit            pend_valid = 1'b0;
    int            pend_addr = 0;
    logic [DW-1:0] pend_old = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_edge) begin
            chk("rst_reply", {63'd0, mem_reply}, 64'd0);
            chk("rst_busy",  {63'd0, mem_busy},  64'd0);
            chk("rst_err",   {63'd0, mem_err},   64'd0);
            chk("rst_rdata", {33'd0, mem_rdata}, 64'd0);
            chk("rst_pos",   {61'd0, drum_pos},  64'd0);
        end else begin
            if (mem_reply) begin
                if (sb.size() == 0) begin
                    chk("unexpected_reply", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("reply_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.rd) rdata_m = e.data;
                    else      pend_valid = 1'b0;
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missing_reply", 64'(cyc), 64'(e.cyc));
                if (!e.rd) pend_valid = 1'b0;
            end
            chk("rdata", {33'd0, mem_rdata}, {33'd0, rdata_m});
            chk("busy", {63'd0, mem_busy}, {63'd0, (cyc > cur_t && cyc <= cur_reply)});
            chk("err", {63'd0, mem_err}, {63'd0, (cyc >= err_from)});
            chk("drum_pos", {61'd0, drum_pos}, 64'(((cyc / SC) % NW)));
        end
    end

    // Caller must be at a negedge; returns at the negedge of cycle 0.
    task automatic do_reset(input int n);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        cur_t = -1;
        cur_reply = -1;
        err_from = NEVER;
        rdata_m = '0;
        if (pend_valid) mem_m[pend_addr] = pend_old;
        pend_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle();
        wait_cyc(cur_reply + 1);
    endtask

    // Issues a pulse in the current cycle and records the expectation.
    task automatic req(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   t;
        exp_t e;
`ifdef DRUM_LATENCY_EN
        int   m;
`endif
        t = cyc;
        mem_read_pulse  = rd;
        mem_write_pulse = wr;
        mem_addr        = a;
        mem_wdata       = d;
        if (rd && wr && err_from > t + 1) err_from = t + 1;
        if (t > cur_reply) begin
`ifdef DRUM_LATENCY_EN
            // first word time of address a that ends after cycle t
            m = t + 1;
            while (!(((m / SC) % NW) == int'(a) && (m % SC) == SC - 1)) m++;
            e.cyc = m + 1;
`else
            e.cyc = t + 2;
`endif
            e.rd = !wr;
            if (wr) begin
                pend_valid = 1'b1;
                pend_addr  = int'(a);
                pend_old   = mem_m[a];
                mem_m[a]   = d;
                e.data     = d;
            end else begin
                e.data = mem_m[a];
            end
            cur_t = t;
            cur_reply = e.cyc;
            sb.push_back(e);
        end else if (err_from > t + 1) begin
            err_from = t + 1;
        end
        @(negedge clk);
        mem_read_pulse  = 1'b0;
        mem_write_pulse = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  r;
        bit  rd;
        bit  wr;
        do_reset(3);

        // give every word a known value
        for (int i = 0; i < NW; i++) begin
            req(1'b0, 1'b1, AW'(i), DW'($urandom));
            wait_idle();
        end

        // write then read back
        do_reset(2);
        req(1'b0, 1'b1, 3'd3, 31'h1234);
        wait_cyc(9);
        req(1'b1, 1'b0, 3'd3, '0);
        wait_idle();

        // request just before the match edge: minimum latency
        do_reset(2);
        req(1'b1, 1'b0, 3'd0, '0);
        wait_idle();

        // request in the match cycle itself: full revolution
        do_reset(2);
        wait_cyc(1);
        req(1'b1, 1'b0, 3'd0, '0);
        wait_idle();

        // wrap-around of drum_pos
        do_reset(2);
        wait_cyc(15);
        req(1'b1, 1'b0, 3'd7, '0);
        wait_idle();

        // second pulse while a request is in flight
        do_reset(2);
        req(1'b1, 1'b0, 3'd2, '0);
        wait_cyc(3);
        req(1'b1, 1'b0, 3'd6, '0);
        wait_idle();
        wait_cyc(cyc + 3);

        // simultaneous read and write pulses
        do_reset(2);
        req(1'b1, 1'b1, 3'd4, DW'($urandom));
        wait_idle();
        req(1'b1, 1'b0, 3'd4, '0);
        wait_idle();

        // reset abandons a pending write
        do_reset(2);
        req(1'b0, 1'b1, 3'd5, 31'h55);
        wait_cyc(4);
        do_reset(2);
        req(1'b1, 1'b0, 3'd5, '0);
        wait_idle();

        // random traffic, including pulses that collide with busy/reply
        do_reset(2);
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            r  = int'($urandom_range(0, 9));
            rd = (r < 5) || (r == 9);
            wr = (r >= 5);
            req(rd, wr, AW'($urandom_range(0, NW - 1)), DW'($urandom));
        end
        wait_idle();
        wait_cyc(cyc + 4);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
